// File: rtl/max_exp_pkg.sv
// Shared types and helpers for the maximum-exponent tracker.
package max_exp_pkg;

    localparam int unsigned N_DEF      = 9;
    localparam int unsigned EXP_W_DEF  = 6;
    localparam int unsigned BEAT_W_DEF = 8;

    // Candidate tuples carry fixed-width fields so one type serves every
    // parameterisation; narrower exponents and lane indices are zero-extended.
    localparam int unsigned CAND_EXP_W  = 16;
    localparam int unsigned CAND_LANE_W = 8;

    // S1 holds one tuple per lane pair, plus the odd lane when N is odd.
    function automatic int unsigned s1_width(input int unsigned n);
        return (n + 1) / 2;
    endfunction

    typedef struct packed {
        logic                   vld;
        logic [CAND_EXP_W-1:0]  exp;
        logic [CAND_LANE_W-1:0] lane;
    } cand_t;

    // True when a must be selected over b: invalid never wins, larger
    // exponent wins, equal exponents resolve to the lower lane index.
    function automatic logic cand_a_wins(input cand_t a, input cand_t b);
        if (!a.vld) begin
            return 1'b0;
        end
        if (!b.vld) begin
            return 1'b1;
        end
        if (a.exp != b.exp) begin
            return a.exp > b.exp;
        end
        return a.lane <= b.lane;
    endfunction

endpackage

// File: rtl/max_exp_cmp_node.sv
// One comparator of the reduction tree: forwards the winning candidate.
module max_exp_cmp_node
    import max_exp_pkg::*;
(
    input  cand_t i_a,
    input  cand_t i_b,
    output cand_t o_win_c
);

    assign o_win_c = cand_a_wins(i_a, i_b) ? i_a : i_b;

endmodule

// File: rtl/max_exp_tracker.sv
// Pipelined maximum-exponent finder with multi-beat accumulation and a
// valid/ready result port. S1 registers the first comparator level, S2
// finishes the tree, merges with the accumulator and loads the result.
module max_exp_tracker
    import max_exp_pkg::*;
#(
    parameter int unsigned N      = N_DEF,
    parameter int unsigned EXP_W  = EXP_W_DEF,
    parameter int unsigned BEAT_W = BEAT_W_DEF,
    parameter int unsigned LANE_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode_acc,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [N-1:0]         in_skip,
    input  logic [N*EXP_W-1:0]   in_exp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W-1:0]     out_max_exp,
    output logic [LANE_W-1:0]    out_lane,
    output logic [BEAT_W-1:0]    out_beat,
    output logic                 out_all_skip,
    output logic [50:0]          number
);

    localparam int unsigned M     = s1_width(N);
    localparam int unsigned NODES = 2 * M - 1;

    cand_t              w_leaf [N];
    cand_t              w_l1   [M];
    cand_t              w_node [NODES];
    cand_t              w_beat;
    cand_t              w_merged;
    logic [BEAT_W-1:0]  w_merged_beat;
    logic [BEAT_W-1:0]  w_beat_cnt_nxt;
    logic               w_stall;
    logic               w_s2_fire;
    logic               w_close;

    cand_t              r_s1_cand [M];
    logic               r_s1_vld;
    logic               r_s1_mode;
    logic               r_s1_last;

    cand_t              r_acc;
    logic [BEAT_W-1:0]  r_acc_beat;
    logic [BEAT_W-1:0]  r_beat_cnt;

    logic               r_out_valid;
    logic [EXP_W-1:0]   r_out_max_exp;
    logic [LANE_W-1:0]  r_out_lane;
    logic [BEAT_W-1:0]  r_out_beat;
    logic               r_out_all_skip;

    // A held result blocks the whole pipeline; the input sees it immediately.
    assign w_stall   = r_out_valid & ~out_ready;
    assign in_ready  = ~w_stall;
    assign w_s2_fire = r_s1_vld & ~w_stall;
    assign w_close   = ~r_s1_mode | r_s1_last;

    // Lane leaves: skipped lanes enter the tree as invalid candidates.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            w_leaf[i].vld  = ~in_skip[i];
            w_leaf[i].exp  = CAND_EXP_W'(in_exp[i*EXP_W +: EXP_W]);
            w_leaf[i].lane = CAND_LANE_W'(i);
        end
    end

    // First pairwise level, feeding the S1 register.
    for (genvar gp = 0; gp < int'(N / 2); gp++) begin : g_l1
        max_exp_cmp_node u_cmp (
            .i_a     (w_leaf[2*gp]),
            .i_b     (w_leaf[2*gp+1]),
            .o_win_c (w_l1[gp])
        );
    end

    // The unpaired top lane bypasses the first level.
    if ((N % 2) == 1) begin : g_odd
        assign w_l1[M-1] = w_leaf[N-1];
    end

    // S1 register: captures level-one winners and the beat's control bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_mode <= 1'b0;
            r_s1_last <= 1'b0;
            for (int j = 0; j < int'(M); j++) begin
                r_s1_cand[j] <= '0;
            end
        end else if (!w_stall) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_mode <= mode_acc;
                r_s1_last <= in_last;
                for (int j = 0; j < int'(M); j++) begin
                    r_s1_cand[j] <= w_l1[j];
                end
            end
        end
    end

    // S2 tree: node M+k combines nodes 2k and 2k+1; the last node is the root.
    for (genvar gl = 0; gl < int'(M); gl++) begin : g_s2_leaf
        assign w_node[gl] = r_s1_cand[gl];
    end

    for (genvar gk = 0; gk < int'(M) - 1; gk++) begin : g_s2
        max_exp_cmp_node u_cmp (
            .i_a     (w_node[2*gk]),
            .i_b     (w_node[2*gk+1]),
            .o_win_c (w_node[int'(M)+gk])
        );
    end

    assign w_beat = w_node[NODES-1];

    // Cross-beat merge: a later beat replaces the running maximum only when
    // strictly greater, so the earliest beat keeps ties.
    always_comb begin
        w_merged      = r_acc;
        w_merged_beat = r_acc_beat;
        if (w_beat.vld && (!r_acc.vld || (w_beat.exp > r_acc.exp))) begin
            w_merged      = w_beat;
            w_merged_beat = r_beat_cnt;
        end
    end

    // Beat index saturates so very long groups keep reporting a valid index.
    assign w_beat_cnt_nxt = (r_beat_cnt == '1) ? r_beat_cnt : r_beat_cnt + BEAT_W'(1);

    // Accumulator and beat counter: cleared on group close, else advanced.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_acc_beat <= '0;
            r_beat_cnt <= '0;
        end else if (w_s2_fire) begin
            if (w_close) begin
                r_acc      <= '0;
                r_acc_beat <= '0;
                r_beat_cnt <= '0;
            end else begin
                r_acc      <= w_merged;
                r_acc_beat <= w_merged_beat;
                r_beat_cnt <= w_beat_cnt_nxt;
            end
        end
    end

    // Output register: loads on close, including the cycle the old result
    // is accepted; fields hold while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid    <= 1'b0;
            r_out_max_exp  <= '0;
            r_out_lane     <= '0;
            r_out_beat     <= '0;
            r_out_all_skip <= 1'b0;
        end else if (!w_stall) begin
            r_out_valid <= w_s2_fire & w_close;
            if (w_s2_fire && w_close) begin
                r_out_all_skip <= ~w_merged.vld;
                r_out_max_exp  <= w_merged.vld ? EXP_W'(w_merged.exp)   : '0;
                r_out_lane     <= w_merged.vld ? LANE_W'(w_merged.lane) : '0;
                r_out_beat     <= w_merged.vld ? w_merged_beat          : '0;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_max_exp  = r_out_max_exp;
    assign out_lane     = r_out_lane;
    assign out_beat     = r_out_beat;
    assign out_all_skip = r_out_all_skip;
    assign number       = '0;

endmodule
